// File: rtl/fetch_pkg.sv
// fetch_pkg -- shared constants and helpers for the LEGv8 instruction-fetch stage.
//   COND_BR_OP / CBZ_OP : opcode bytes (instr[31:24]) of the conditional branches
//   PC_INC              : sequential PC increment
//   NOP_INSTR           : value held by the IF/ID instruction register after reset
//   is_cond_br()        : 1 when an instruction word is B.cond or CBZ
package fetch_pkg;

    localparam logic [7:0]  COND_BR_OP = 8'h54;
    localparam logic [7:0]  CBZ_OP     = 8'hB4;
    localparam logic [63:0] PC_INC     = 64'd4;
    localparam logic [31:0] NOP_INSTR  = 32'h0;

    function automatic logic is_cond_br(input logic [31:0] instr);
        return (instr[31:24] == COND_BR_OP) || (instr[31:24] == CBZ_OP);
    endfunction

endpackage

// File: rtl/alt_pc_fifo.sv
// alt_pc_fifo -- FIFO of alternate (not-predicted) PCs, one entry per
// conditional branch in flight between fetch and resolution.
//   clk, reset (async, active-high), en (global hold when 0)
//   push/din  : enqueue an alternate PC
//   pop       : dequeue the head (ignored when empty)
//   clear     : discard every entry (rd_ptr jumps to wr_ptr); wins over push/pop
//   dout      : head entry, combinational
//   full/empty: occupancy flags
// Pointers are log2(DEPTH)+1 bits so full and empty are told apart by the
// pointer difference; they wrap naturally.
module alt_pc_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic        push,
    input  logic        pop,
    input  logic        clear,
    input  logic [63:0] din,
    output logic [63:0] dout,
    output logic        full,
    output logic        empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]  wr_ptr_reg;
    logic [AW:0]  rd_ptr_reg;
    logic [AW:0]  count;
    logic         do_push;
    logic         do_pop;
    logic [63:0]  mem [DEPTH];

    assign count = wr_ptr_reg - rd_ptr_reg;
    assign full  = (count == (AW+1)'(DEPTH));
    assign empty = (count == '0);

    // A push into a full FIFO is only accepted when a pop frees a slot in the
    // same cycle.
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else if (en) begin
            if (clear) begin
                rd_ptr_reg <= wr_ptr_reg;
            end else begin
                if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
                if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
        end
    end

    // Storage needs no reset: an entry is only read after it has been written.
    always_ff @(posedge clk) begin
        if (en && do_push && !clear) begin
            mem[wr_ptr_reg[AW-1:0]] <= din;
        end
    end

    assign dout = mem[rd_ptr_reg[AW-1:0]];

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit -- IF stage of the pipelined LEGv8 CPU.
// Holds the PC, selects the next PC from the branch prediction supplied by
// hazard detection, registers the IF/ID latch and tracks the alternate PC of
// every in-flight conditional branch so a misprediction can restart fetch.
//   clk, reset (async, active-high), en (global hold)
//   IMem_Addr/IMem_Data          : combinational instruction memory interface
//   TakeBranch, IF_Address       : prediction and byte offset for the current instr
//   Stall                        : load-use stall, holds PC and IF/ID
//   Flush, Br_Resolve            : oldest branch resolves; Flush marks a mispredict
//   IF_ID_PC/Instruction/Valid   : IF/ID pipeline latch
//   Fetch_Full_Stall             : fetch blocked on a full alternate-PC FIFO
//   Perf_*                       : performance counters
// Build option: define FETCH_PERF_CNT_EN to build the three saturating
// performance counters; otherwise the Perf_* outputs are tied to zero.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [63:0] RESET_PC = 64'h0,
    parameter int          DEPTH    = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    output logic [63:0] IMem_Addr,
    input  logic [31:0] IMem_Data,
    input  logic        TakeBranch,
    input  logic [63:0] IF_Address,
    input  logic        Stall,
    input  logic        Flush,
    input  logic        Br_Resolve,
    output logic [63:0] IF_ID_PC,
    output logic [31:0] IF_ID_Instruction,
    output logic        IF_ID_Valid,
    output logic        Fetch_Full_Stall,
    output logic [31:0] Perf_Fetched,
    output logic [31:0] Perf_Mispredicts,
    output logic [31:0] Perf_FullStalls
);

    logic [63:0] pc_reg;
    logic [63:0] if_id_pc_reg;
    logic [31:0] if_id_instr_reg;
    logic        if_id_valid_reg;

    logic        is_cond;
    logic [63:0] seq_pc;
    logic [63:0] tgt_pc;
    logic [63:0] npc;
    logic [63:0] alt_pc;
    logic        fifo_full;
    logic        fifo_empty;
    logic [63:0] fifo_head;
    logic        pop;
    logic        recover;
    logic        full_stall;
    logic        advance;
    logic        push;

    assign is_cond = is_cond_br(IMem_Data);
    assign seq_pc  = pc_reg + PC_INC;
    assign tgt_pc  = pc_reg + IF_Address;
    assign npc     = TakeBranch ? tgt_pc : seq_pc;
    assign alt_pc  = TakeBranch ? seq_pc : tgt_pc;

    // A resolve on an empty FIFO has no prediction behind it, so it is
    // ignored entirely, recovery included.
    assign pop        = Br_Resolve & ~fifo_empty;
    assign recover    = Br_Resolve & Flush & ~fifo_empty;
    // pop covers recover, so a recovery never reports a full stall.
    assign full_stall = is_cond & fifo_full & ~pop;
    assign advance    = en & ~Stall & ~recover & ~full_stall;
    assign push       = advance & is_cond;

    alt_pc_fifo #(
        .DEPTH (DEPTH)
    ) u_alt_fifo (
        .clk   (clk),
        .reset (reset),
        .en    (en),
        .push  (push),
        .pop   (pop),
        .clear (recover),
        .din   (alt_pc),
        .dout  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Priority: recover > stall > full-FIFO bubble > normal advance.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_reg          <= RESET_PC;
            if_id_pc_reg    <= 64'h0;
            if_id_instr_reg <= NOP_INSTR;
            if_id_valid_reg <= 1'b0;
        end else if (en) begin
            if (recover) begin
                pc_reg          <= fifo_head;
                if_id_valid_reg <= 1'b0;
            end else if (Stall) begin
                pc_reg          <= pc_reg;
            end else if (full_stall) begin
                if_id_valid_reg <= 1'b0;
            end else begin
                pc_reg          <= npc;
                if_id_pc_reg    <= pc_reg;
                if_id_instr_reg <= IMem_Data;
                if_id_valid_reg <= 1'b1;
            end
        end
    end

    assign IMem_Addr         = pc_reg;
    assign IF_ID_PC          = if_id_pc_reg;
    assign IF_ID_Instruction = if_id_instr_reg;
    assign IF_ID_Valid       = if_id_valid_reg;
    assign Fetch_Full_Stall  = full_stall;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetched_reg;
    logic [31:0] mispredicts_reg;
    logic [31:0] full_stalls_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetched_reg     <= '0;
            mispredicts_reg <= '0;
            full_stalls_reg <= '0;
        end else if (en) begin
            if (advance && fetched_reg != '1)
                fetched_reg <= fetched_reg + 32'd1;
            if (recover && mispredicts_reg != '1)
                mispredicts_reg <= mispredicts_reg + 32'd1;
            if (full_stall && full_stalls_reg != '1)
                full_stalls_reg <= full_stalls_reg + 32'd1;
        end
    end

    assign Perf_Fetched     = fetched_reg;
    assign Perf_Mispredicts = mispredicts_reg;
    assign Perf_FullStalls  = full_stalls_reg;
`else
    assign Perf_Fetched     = 32'd0;
    assign Perf_Mispredicts = 32'd0;
    assign Perf_FullStalls  = 32'd0;
`endif

`ifndef SYNTHESIS
    // Protocol checks on the resolve interface from the execute stage.
    always @(posedge clk) begin
        if (!reset && en) begin
            assert (!(Br_Resolve && fifo_empty))
                else $error("fetch_unit: Br_Resolve with no branch in flight");
            assert (!(Flush && !Br_Resolve))
                else $error("fetch_unit: Flush without Br_Resolve");
        end
    end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit -- directed self-checking bench for fetch_unit
// (RESET_PC = 0, DEPTH = 4). Every expected value is hand-computed below.
module tb_fetch_unit;

    logic        clk;
    logic        reset;
    logic        en;
    logic [63:0] IMem_Addr;
    logic [31:0] IMem_Data;
    logic        TakeBranch;
    logic [63:0] IF_Address;
    logic        Stall;
    logic        Flush;
    logic        Br_Resolve;
    logic [63:0] IF_ID_PC;
    logic [31:0] IF_ID_Instruction;
    logic        IF_ID_Valid;
    logic        Fetch_Full_Stall;
    logic [31:0] Perf_Fetched;
    logic [31:0] Perf_Mispredicts;
    logic [31:0] Perf_FullStalls;

    int total_cnt = 0;
    int bad_cnt   = 0;

    localparam logic [31:0] ADD_I = 32'h8B000000;   // non-branch
    localparam logic [31:0] BC_I  = 32'h54000040;   // B.cond
    localparam logic [31:0] BC2_I = 32'h54000080;   // B.cond
    localparam logic [31:0] CBZ_I = 32'hB4000040;   // CBZ

    fetch_unit #(
        .RESET_PC (64'h0),
        .DEPTH    (4)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .en                (en),
        .IMem_Addr         (IMem_Addr),
        .IMem_Data         (IMem_Data),
        .TakeBranch        (TakeBranch),
        .IF_Address        (IF_Address),
        .Stall             (Stall),
        .Flush             (Flush),
        .Br_Resolve        (Br_Resolve),
        .IF_ID_PC          (IF_ID_PC),
        .IF_ID_Instruction (IF_ID_Instruction),
        .IF_ID_Valid       (IF_ID_Valid),
        .Fetch_Full_Stall  (Fetch_Full_Stall),
        .Perf_Fetched      (Perf_Fetched),
        .Perf_Mispredicts  (Perf_Mispredicts),
        .Perf_FullStalls   (Perf_FullStalls)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total_cnt++;
        if (got !== exp) begin
            bad_cnt++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end else begin
            $display("ok   %s got=%h", tag, got);
        end
    endtask

    // Drive one cycle's worth of inputs (called just after a rising edge).
    task automatic drive(input logic [31:0] instr, input logic tb, input logic [63:0] off,
                         input logic br, input logic fl, input logic st);
        IMem_Data  = instr;
        TakeBranch = tb;
        IF_Address = off;
        Br_Resolve = br;
        Flush      = fl;
        Stall      = st;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1;
        en    = 1'b1;
        drive(ADD_I, 1'b0, 64'h0, 1'b0, 1'b0, 1'b0);
        #1;
        check("rst_addr",  IMem_Addr, 64'h0);
        check("rst_valid", {63'h0, IF_ID_Valid}, 64'h0);
        check("rst_ifpc",  IF_ID_PC, 64'h0);
        check("rst_instr", {32'h0, IF_ID_Instruction}, 64'h0);
        check("rst_perf",  {32'h0, Perf_Fetched | Perf_Mispredicts | Perf_FullStalls}, 64'h0);
        #11 reset = 1'b0;

        // Sequential fetch 0 -> 4 -> 8 -> C -> 10
        step();
        check("seq1_addr",  IMem_Addr, 64'h4);
        check("seq1_valid", {63'h0, IF_ID_Valid}, 64'h1);
        check("seq1_ifpc",  IF_ID_PC, 64'h0);
        check("seq1_instr", {32'h0, IF_ID_Instruction}, {32'h0, ADD_I});
        step();
        check("seq2_addr",  IMem_Addr, 64'h8);
        check("seq2_ifpc",  IF_ID_PC, 64'h4);
        step();
        step();
        check("seq4_addr",  IMem_Addr, 64'h10);

        // Predicted taken at 0x10, offset 0x20 -> 0x30, alt 0x14
        drive(BC_I, 1'b1, 64'h20, 1'b0, 1'b0, 1'b0);
        #1 check("tk_nofull", {63'h0, Fetch_Full_Stall}, 64'h0);
        step();
        check("tk_addr",  IMem_Addr, 64'h30);
        check("tk_ifpc",  IF_ID_PC, 64'h10);
        check("tk_instr", {32'h0, IF_ID_Instruction}, {32'h0, BC_I});
        // Mispredict -> restart at 0x14, bubble
        drive(ADD_I, 1'b0, 64'h0, 1'b1, 1'b1, 1'b0);
        step();
        check("rec1_addr",  IMem_Addr, 64'h14);
        check("rec1_valid", {63'h0, IF_ID_Valid}, 64'h0);
        drive(ADD_I, 1'b0, 64'h0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 11; i++) step();
        check("walk_addr", IMem_Addr, 64'h40);

        // Predicted not-taken CBZ at 0x40, offset 8 -> 0x44, alt 0x48
        drive(CBZ_I, 1'b0, 64'h8, 1'b0, 1'b0, 1'b0);
        step();
        check("nt_addr", IMem_Addr, 64'h44);
        // Correct prediction resolves: plain pop, sequential fetch continues
        drive(ADD_I, 1'b0, 64'h0, 1'b1, 1'b0, 1'b0);
        step();
        check("nt_res_addr",  IMem_Addr, 64'h48);
        check("nt_res_valid", {63'h0, IF_ID_Valid}, 64'h1);
        check("nt_res_ifpc",  IF_ID_PC, 64'h44);

        // Two branches in flight: alt 0x148 then alt 0x50
        drive(CBZ_I, 1'b0, 64'h100, 1'b0, 1'b0, 1'b0);
        step();
        drive(BC2_I, 1'b1, 64'h10, 1'b0, 1'b0, 1'b0);
        step();
        check("pre_st_addr", IMem_Addr, 64'h5C);

        // Stall 3 cycles; resolve (no flush) in the second pops 0x148
        for (int i = 0; i < 3; i++) begin
            drive(ADD_I, 1'b0, 64'h0, (i == 1), 1'b0, 1'b1);
            step();
            check("st_addr",  IMem_Addr, 64'h5C);
            check("st_ifpc",  IF_ID_PC, 64'h4C);
            check("st_instr", {32'h0, IF_ID_Instruction}, {32'h0, BC2_I});
            check("st_valid", {63'h0, IF_ID_Valid}, 64'h1);
        end
        // Head must now be 0x50, proving exactly one pop during the stall
        drive(ADD_I, 1'b0, 64'h0, 1'b1, 1'b1, 1'b0);
        step();
        check("rec2_addr", IMem_Addr, 64'h50);

        // Fill FIFO: CBZ not-taken at 0x50..0x5C, alts 0x1050..0x105C
        for (int i = 0; i < 4; i++) begin
            drive(CBZ_I, 1'b0, 64'h1000, 1'b0, 1'b0, 1'b0);
            #1 check("fill_nofull", {63'h0, Fetch_Full_Stall}, 64'h0);
            step();
        end
        check("fill_addr", IMem_Addr, 64'h60);
        // Fifth branch blocks
        drive(CBZ_I, 1'b0, 64'h1000, 1'b0, 1'b0, 1'b0);
        #1 check("full_flag", {63'h0, Fetch_Full_Stall}, 64'h1);
        step();
        check("full_addr",  IMem_Addr, 64'h60);
        check("full_valid", {63'h0, IF_ID_Valid}, 64'h0);
        // Resolve lets it through: push and pop same cycle
        drive(CBZ_I, 1'b0, 64'h1000, 1'b1, 1'b0, 1'b0);
        #1 check("pp_flag", {63'h0, Fetch_Full_Stall}, 64'h0);
        step();
        check("pp_addr",  IMem_Addr, 64'h64);
        check("pp_ifpc",  IF_ID_PC, 64'h60);
        check("pp_valid", {63'h0, IF_ID_Valid}, 64'h1);
        // Count still 4: another branch is blocked
        drive(CBZ_I, 1'b0, 64'h1000, 1'b0, 1'b0, 1'b0);
        #1 check("pp_full", {63'h0, Fetch_Full_Stall}, 64'h1);
        // Mispredict: head is alt of branch at 0x54
        drive(CBZ_I, 1'b0, 64'h1000, 1'b1, 1'b1, 1'b0);
        step();
        check("rec3_addr",  IMem_Addr, 64'h1054);
        check("rec3_valid", {63'h0, IF_ID_Valid}, 64'h0);

`ifdef FETCH_PERF_CNT_EN
        check("perf_fetched", {32'h0, Perf_Fetched}, 64'd25);
        check("perf_mispred", {32'h0, Perf_Mispredicts}, 64'd3);
        check("perf_fullst",  {32'h0, Perf_FullStalls}, 64'd1);
`else
        check("perf_fetched", {32'h0, Perf_Fetched}, 64'd0);
        check("perf_mispred", {32'h0, Perf_Mispredicts}, 64'd0);
        check("perf_fullst",  {32'h0, Perf_FullStalls}, 64'd0);
`endif

        // Async reset between edges, in the middle of another recovery
        drive(ADD_I, 1'b0, 64'h0, 1'b1, 1'b1, 1'b0);
        #2 reset = 1'b1;
        #1;
        check("arst_addr",  IMem_Addr, 64'h0);
        check("arst_valid", {63'h0, IF_ID_Valid}, 64'h0);
        check("arst_ifpc",  IF_ID_PC, 64'h0);
        check("arst_instr", {32'h0, IF_ID_Instruction}, 64'h0);
        check("arst_perf",  {32'h0, Perf_Fetched | Perf_Mispredicts | Perf_FullStalls}, 64'h0);
        drive(ADD_I, 1'b0, 64'h0, 1'b0, 1'b0, 1'b0);
        step();
        reset = 1'b0;
        #1 check("post_addr0", IMem_Addr, 64'h0);
        step();
        check("post_addr1", IMem_Addr, 64'h4);
        check("post_ifpc",  IF_ID_PC, 64'h0);
        check("post_valid", {63'h0, IF_ID_Valid}, 64'h1);

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
IF stage of the pipelined LEGv8 CPU. It holds the PC, drives the instruction-memory address, and picks the next PC from the predicted-branch controls (TakeBranch, IF_Address) produced by the hazard-detection stage. It also registers the IF/ID pipeline latch and keeps a small FIFO of alternate (not-predicted) PCs. On a misprediction it restores fetch from that FIFO.

Parameters:
RESET_PC, 64'h0, PC value loaded on reset.
DEPTH, 4, entries in the alternate-PC FIFO; power of two, at least 2.

Ports:
clk  input  1  system clock; all state updates on the rising edge
reset  input  1  asynchronous, active-high; clears all state immediately
en  input  1  global enable; when 0, all state including the FIFO holds
IMem_Addr  output  64  current PC, driven to the combinational instruction memory
IMem_Data  input  32  instruction at IMem_Addr, valid in the same cycle
TakeBranch  input  1  predicted-taken for the instruction now on IMem_Data
IF_Address  input  64  sign-extended byte offset of that branch
Stall  input  1  load-use stall; hold PC and IF/ID
Flush  input  1  misprediction flag; qualified by Br_Resolve
Br_Resolve  input  1  the oldest in-flight conditional branch resolves this cycle
IF_ID_PC  output  64  registered PC of the latched instruction
IF_ID_Instruction  output  32  registered instruction
IF_ID_Valid  output  1  0 means the latch holds a bubble
Fetch_Full_Stall  output  1  combinational; 1 when fetch is blocked because the FIFO is full
Perf_Fetched, Perf_Mispredicts, Perf_FullStalls  output  32 each  performance counters (see Optional Feature)

Behaviour:
- Reset (async): PC = RESET_PC; IF_ID_PC = 0; IF_ID_Instruction = 32'h0; IF_ID_Valid = 0; FIFO empty with both pointers 0; all counters 0.
- Conditional-branch decode: IsCond = IMem_Data[31:24] is 8'h54 (B.cond) or 8'hB4 (CBZ).
- Sequential PC: seq = PC + 4. Target: tgt = PC + IF_Address. Both are 64-bit adds that wrap modulo 2^64.
- Predicted next PC: npc = TakeBranch ? tgt : seq.
- Alternate PC: alt = TakeBranch ? seq : tgt.
- Fetch-advance condition: en & ~Stall & ~recover & ~(IsCond & full & ~pop).
  - recover = Br_Resolve & Flush.
  - pop = Br_Resolve & ~empty.
- On a fetch-advance cycle:
  - PC <= npc.
  - IF/ID <= {PC, IMem_Data, 1}.
  - If IsCond, push alt.
- FIFO full, IsCond, no pop: Fetch_Full_Stall = 1. PC holds; IF_ID_Valid <= 0 (bubble inserted); no push.
- Stall = 1: PC and the whole IF/ID latch hold; no push. A pop still occurs if Br_Resolve = 1.
- Recover cycle (en = 1, recover = 1):
  - PC <= head alt.
  - FIFO cleared (rd_ptr = wr_ptr, count 0); younger predictions are discarded.
  - IF_ID_Valid <= 0.
  - Recover overrides both Stall and Fetch_Full_Stall.
- Br_Resolve with Flush = 0: plain pop.
- Br_Resolve on an empty FIFO: ignored. Flush without Br_Resolve: ignored. Both raise a simulation-only assertion error.
- Push and pop in the same cycle: both are performed; count is unchanged. A push is legal when the FIFO is full if a pop happens that cycle.
- FIFO pointers are log2(DEPTH)+1 bits and wrap naturally. full when count == DEPTH; empty when count == 0.
- Latency: PC to IF/ID is 1 cycle. Misprediction to correct PC on IMem_Addr is 1 cycle after the Br_Resolve edge.
- Reset asserted mid-operation discards all in-flight state; the first fetch after deassertion is from RESET_PC.

Optional Feature:
Macro FETCH_PERF_CNT_EN.
- Defined: three 32-bit saturating counters, gated by en.
  - Perf_Fetched increments on each fetch-advance.
  - Perf_Mispredicts increments on each recover cycle.
  - Perf_FullStalls increments on each Fetch_Full_Stall cycle.
- Undefined: the counters are not built and all three outputs are tied to 0. Port list is identical in both builds.

Decomposition:
- Package fetch_pkg holds:
  - COND_BR_OP = 8'h54
  - CBZ_OP = 8'hB4
  - PC_INC = 64'd4
  - NOP_INSTR = 32'h0
  - function is_cond_br(logic [31:0])
- Sub-module alt_pc_fifo (parameter DEPTH), with ports:
  - clk, reset, en, push, pop, clear, din[63:0]
  - dout[63:0], full, empty
- Next-PC muxing and the IF/ID latch stay in fetch_unit.

Test Plan:
- Reset: release reset with RESET_PC = 0 and non-branch instructions, no stalls -> IMem_Addr steps 0, 4, 8; IF_ID_Valid = 1 from the second edge; IF_ID_PC trails by one cycle.
- Predicted taken: at PC 0x10, IMem_Data = 32'h54000040, TakeBranch = 1, IF_Address = 0x20 -> next PC 0x30, FIFO holds 0x14. Then Br_Resolve = 1, Flush = 1 -> PC 0x14, IF_ID_Valid = 0, FIFO empty.
- Predicted not-taken: at PC 0x40, 32'hB4000040, TakeBranch = 0, IF_Address = 0x8 -> next PC 0x44, FIFO holds 0x48. Then Br_Resolve = 1, Flush = 0 -> FIFO empty, fetch continues sequentially.
- Stall: Stall = 1 for 3 cycles -> PC and IF/ID constant. Br_Resolve during the stall pops one entry; FIFO count drops by 1.
- FIFO full: fetch DEPTH + 1 consecutive conditional branches with no resolves -> Fetch_Full_Stall = 1 on the fifth, PC holds, bubble inserted. Then Br_Resolve with the branch present -> push and pop in the same cycle, count stays 4.
- Async reset mid-recovery: assert reset between edges -> all outputs return to reset values immediately. With FETCH_PERF_CNT_EN defined, Perf_Mispredicts equals the number of recover cycles in the earlier tests.
